// File: rtl/sfx_sequencer.sv
// -----------------------------------------------------------------------------
// sfx_sequencer
//   Sequences and arbitrates the Pong sound effects (paddle-hit and score)
//   onto one shared tone path. A beat index steps through the selected tone
//   table at a fixed beat rate; the selected table's tone is forwarded to the
//   PWM note generator, or SILENCE while idle.
//
//   Optional feature macro: SFX_PREEMPT_EN
//     defined   : a score request during a hit sound restarts as score at once
//     undefined : a score request during a hit sound is queued as pending
//
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous reset, active low
//   req_hit     in   1   1-cycle pulse: play hit sound
//   req_score   in   1   1-cycle pulse: play score sound
//   tone_hit    in   32  tone from hit table, indexed by beat_num
//   tone_score  in   32  tone from score table, indexed by beat_num
//   beat_num    out  8   beat index driven to both tables
//   sel_score   out  1   1 = score sound active, 0 = hit
//   tone        out  32  selected tone; SILENCE when idle
//   busy        out  1   sound in progress
//   done        out  1   1-cycle pulse when a sound finishes naturally
// -----------------------------------------------------------------------------
module sfx_sequencer #(
    parameter int          BEAT_DIV  = 25_000_000,
    parameter int          HIT_LEN   = 6,
    parameter int          SCORE_LEN = 7,
    parameter logic [31:0] SILENCE   = 32'd20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_hit,
    input  logic        req_score,
    input  logic [31:0] tone_hit,
    input  logic [31:0] tone_score,
    output logic [7:0]  beat_num,
    output logic        sel_score,
    output logic [31:0] tone,
    output logic        busy,
    output logic        done
);

    localparam int             DW         = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST   = DW'(BEAT_DIV - 1);
    localparam logic [7:0]     HIT_LAST   = 8'(HIT_LEN - 1);
    localparam logic [7:0]     SCORE_LAST = 8'(SCORE_LEN - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [0:0]    state;
    logic [DW-1:0] divider;
    logic          pend_hit;
    logic          pend_score;

    logic          wrap;
    logic          at_end;
    logic          hit_pend_nxt;
    logic          score_pend_nxt;
    logic          preempt;

    // Requests arriving while a sound plays are folded into the pending flags
    // first, so an end tick on the same cycle sees them and resolves them.
    // A request for the sound already playing is simply dropped.
    always_comb begin
        wrap         = (divider == DIV_LAST);
        at_end       = wrap && (beat_num == (sel_score ? SCORE_LAST : HIT_LAST));
        hit_pend_nxt = pend_hit | (req_hit & sel_score);
`ifdef SFX_PREEMPT_EN
        preempt        = req_score & ~sel_score;
        score_pend_nxt = pend_score;
`else
        preempt        = 1'b0;
        score_pend_nxt = pend_score | (req_score & ~sel_score);
`endif
    end

    // Main sequencer: start/arbitrate in IDLE; in PLAY step the divider and
    // beat index, then at the last beat's wrap either chain into a pending
    // sound (score wins over hit) or drop back to IDLE. Index 0 is lead-in
    // silence, so every sound starts at beat 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat_num   <= 8'd0;
            sel_score  <= 1'b0;
            done       <= 1'b0;
            divider    <= '0;
            pend_hit   <= 1'b0;
            pend_score <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_score || pend_score) begin
                        state      <= S_PLAY;
                        sel_score  <= 1'b1;
                        beat_num   <= 8'd1;
                        divider    <= '0;
                        pend_score <= 1'b0;
                        pend_hit   <= pend_hit | req_hit;
                    end else if (req_hit || pend_hit) begin
                        state     <= S_PLAY;
                        sel_score <= 1'b0;
                        beat_num  <= 8'd1;
                        divider   <= '0;
                        pend_hit  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (preempt) begin
                        // hit sound is abandoned: no done, not re-queued
                        sel_score <= 1'b1;
                        beat_num  <= 8'd1;
                        divider   <= '0;
                    end else if (at_end) begin
                        done    <= 1'b1;
                        divider <= '0;
                        if (score_pend_nxt) begin
                            sel_score  <= 1'b1;
                            beat_num   <= 8'd1;
                            pend_score <= 1'b0;
                            pend_hit   <= hit_pend_nxt;
                        end else if (hit_pend_nxt) begin
                            sel_score  <= 1'b0;
                            beat_num   <= 8'd1;
                            pend_hit   <= 1'b0;
                            pend_score <= 1'b0;
                        end else begin
                            state      <= S_IDLE;
                            beat_num   <= 8'd0;
                            pend_hit   <= 1'b0;
                            pend_score <= 1'b0;
                        end
                    end else begin
                        pend_hit   <= hit_pend_nxt;
                        pend_score <= score_pend_nxt;
                        if (wrap) begin
                            divider  <= '0;
                            beat_num <= beat_num + 8'd1;
                        end else begin
                            divider <= divider + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_PLAY);
    assign tone = busy ? (sel_score ? tone_score : tone_hit) : SILENCE;

endmodule

// File: tb/tb_sfx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sfx_sequencer
//   Self-checking bench for sfx_sequencer with BEAT_DIV=4. Every cycle is
//   compared against a reference model that describes a sound by the number
//   of cycles elapsed since it started (beat = 1 + elapsed/BEAT_DIV, sound
//   ends after (LEN-1)*BEAT_DIV cycles). Fixed vector tables cover the basic
//   hit and simultaneous-request sequences, hand-written sequences cover
//   the multi-cycle corner cases, and a random phase finishes the run.
//   Honours SFX_PREEMPT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sfx_sequencer;

    localparam int BD  = 4;
    localparam int HL  = 6;
    localparam int SL  = 7;
    localparam logic [31:0] SIL = 32'd20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_hit;
    logic        req_score;
    logic [31:0] tone_hit;
    logic [31:0] tone_score;
    logic [7:0]  beat_num;
    logic        sel_score;
    logic [31:0] tone;
    logic        busy;
    logic        done;

    sfx_sequencer #(
        .BEAT_DIV (BD),
        .HIT_LEN  (HL),
        .SCORE_LEN(SL),
        .SILENCE  (SIL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_hit   (req_hit),
        .req_score (req_score),
        .tone_hit  (tone_hit),
        .tone_score(tone_score),
        .beat_num  (beat_num),
        .sel_score (sel_score),
        .tone      (tone),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    bit rand_tones = 1'b0;

    // reference model state
    bit m_play;
    bit m_snd;      // 1 = score
    int m_el;       // cycles elapsed in current sound
    bit m_ph;
    bit m_ps;
    bit m_done;

    typedef struct {
        bit         rh;
        bit         rs;
        int         n;
        bit         busy;
        logic [7:0] beat;
        bit         sel;
        bit         done;
    } vec_t;

    vec_t vecs[$];

    function automatic int lenOf(bit s);
        return s ? SL : HL;
    endfunction

    task automatic modelReset();
        m_play = 0; m_snd = 0; m_el = 0; m_ph = 0; m_ps = 0; m_done = 0;
    endtask

    task automatic modelStart(bit s);
        m_play = 1; m_snd = s; m_el = 0;
    endtask

    task automatic modelStep(bit rh, bit rs);
        m_done = 0;
        if (!m_play) begin
            if (rs) begin
                modelStart(1);
                m_ph = m_ph | rh;
            end else if (rh) begin
                modelStart(0);
            end
        end else begin
`ifdef SFX_PREEMPT_EN
            if (rs && !m_snd) begin
                modelStart(1);
                return;
            end
`endif
            if (rh && m_snd)  m_ph = 1;
            if (rs && !m_snd) m_ps = 1;
            m_el++;
            if (m_el == (lenOf(m_snd) - 1) * BD) begin
                m_done = 1;
                if (m_ps) begin
                    m_ps = 0;
                    modelStart(1);
                end else if (m_ph) begin
                    m_ph = 0;
                    modelStart(0);
                end else begin
                    m_play = 0;
                end
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] exp_tone;
        logic [7:0]  exp_beat;
        exp_beat = m_play ? 8'(1 + m_el / BD) : 8'd0;
        exp_tone = m_play ? (m_snd ? tone_score : tone_hit) : SIL;
        check("busy", {31'd0, busy}, {31'd0, m_play});
        check("beat_num", {24'd0, beat_num}, {24'd0, exp_beat});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("tone", tone, exp_tone);
        if (m_play) check("sel_score", {31'd0, sel_score}, {31'd0, m_snd});
    endtask

    // Called at a falling edge; drives one cycle of requests and checks
    // the result at the next falling edge.
    task automatic applyStimulus(bit rh, bit rs);
        req_hit   = rh;
        req_score = rs;
        if (rand_tones) begin
            tone_hit   = $urandom;
            tone_score = $urandom;
        end
        @(posedge clk);
        modelStep(rh, rs);
        @(negedge clk);
        req_hit   = 1'b0;
        req_score = 1'b0;
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_beat", {24'd0, beat_num}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sel", {31'd0, sel_score}, 32'd0);
        check("rst_tone", tone, SIL);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(bit rh, bit rs, int n, bit b, logic [7:0] bt, bit s, bit d);
        vec_t v;
        v.rh = rh; v.rs = rs; v.n = n; v.busy = b; v.beat = bt; v.sel = s; v.done = d;
        return v;
    endfunction

    task automatic runVectors(int first, int last);
        for (int i = first; i <= last; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                applyStimulus(k == 0 ? vecs[i].rh : 1'b0, k == 0 ? vecs[i].rs : 1'b0);
                check("vec_busy", {31'd0, busy}, {31'd0, vecs[i].busy});
                check("vec_beat", {24'd0, beat_num}, {24'd0, vecs[i].beat});
                check("vec_done", {31'd0, done}, {31'd0, vecs[i].done});
                if (vecs[i].busy) check("vec_sel", {31'd0, sel_score}, {31'd0, vecs[i].sel});
            end
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int guard;

        rst_n      = 1'b0;
        req_hit    = 1'b0;
        req_score  = 1'b0;
        tone_hit   = 32'd466;
        tone_score = 32'd587;
        modelReset();

        // vectors 0..6: single hit sound
        vecs.push_back(mk(1, 0, 4, 1, 8'd1, 0, 0));
        for (int b = 2; b <= 5; b++) vecs.push_back(mk(0, 0, 4, 1, 8'(b), 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 2, 0, 8'd0, 0, 0));
        // vectors 7..20: simultaneous requests, score then hit
        vecs.push_back(mk(1, 1, 4, 1, 8'd1, 1, 0));
        for (int b = 2; b <= 6; b++) vecs.push_back(mk(0, 0, 4, 1, 8'(b), 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'd1, 0, 1));
        vecs.push_back(mk(0, 0, 3, 1, 8'd1, 0, 0));
        for (int b = 2; b <= 5; b++) vecs.push_back(mk(0, 0, 4, 1, 8'(b), 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 0, 2, 0, 8'd0, 0, 0));

        repeat (2) @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_beat", {24'd0, beat_num}, 32'd0);
        check("init_done", {31'd0, done}, 32'd0);
        check("init_sel", {31'd0, sel_score}, 32'd0);
        check("init_tone", tone, SIL);
        rst_n = 1'b1;
        @(negedge clk);

        // single hit, then both requests together, fixed tones 466/587
        runVectors(0, 6);
        runVectors(7, 20);

        // tone mux with the fixed table values
        applyStimulus(0, 1);
        check("mux_score", tone, 32'd587);
        repeat (3) applyStimulus(0, 0);
        check("mux_score2", tone, 32'd587);
        doReset();
        check("mux_idle", tone, 32'd20000);
        applyStimulus(1, 0);
        check("mux_hit", tone, 32'd466);

        // let it finish, then repeated hit requests during playback
        guard = 0;
        while (busy && guard < 100) begin applyStimulus(0, 0); guard++; end
        check("drain_timeout", {31'd0, busy}, 32'd0);
        applyStimulus(1, 0);
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        guard = 0;
        while (busy && guard < 100) begin
            applyStimulus(guard == 5 || guard == 9, 0);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            guard++;
        end
        check("rehit_timeout", {31'd0, busy}, 32'd0);
        check("rehit_busy_cycles", busy_cnt, 32'd20);
        check("rehit_done_count", done_cnt, 32'd1);

        // score request at hit beat 3
        applyStimulus(1, 0);
        guard = 0;
        while (beat_num != 8'd3 && guard < 50) begin applyStimulus(0, 0); guard++; end
        check("beat3_reached", {24'd0, beat_num}, 32'd3);
        applyStimulus(0, 1);
        done_cnt = done ? 1 : 0;
`ifdef SFX_PREEMPT_EN
        check("preempt_sel", {31'd0, sel_score}, 32'd1);
        check("preempt_beat", {24'd0, beat_num}, 32'd1);
`else
        check("queued_sel", {31'd0, sel_score}, 32'd0);
        check("queued_beat", {24'd0, beat_num}, 32'd3);
`endif
        guard = 0;
        while (busy && guard < 200) begin
            applyStimulus(0, 0);
            if (done) done_cnt++;
            guard++;
        end
        check("sc_timeout", {31'd0, busy}, 32'd0);
`ifdef SFX_PREEMPT_EN
        check("preempt_done_count", done_cnt, 32'd1);
`else
        check("queued_done_count", done_cnt, 32'd2);
`endif

        // reset in the middle of a score sound
        applyStimulus(0, 1);
        guard = 0;
        while (beat_num != 8'd4 && guard < 50) begin applyStimulus(0, 0); guard++; end
        check("beat4_reached", {24'd0, beat_num}, 32'd4);
        doReset();
        applyStimulus(0, 0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        runVectors(0, 6);

        // randomized traffic against the model
        rand_tones = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) doReset();
            applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
